// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: architectural defaults and the IF state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int unsigned PC_STEP_DEFAULT   = 4;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    FULL    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Next-fetch program counter: reset, redirect load (word aligned), sequential step, or hold.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        incr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      // Low two bits of a redirect target are ignored.
      pc_d = target_i & 32'hFFFF_FFFC;
    end else if (incr_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem handshake, one-entry instruction buffer
// held across stalls, NOP bubbles when empty, and redirect handling with in-flight discard.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int unsigned PC_STEP   = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dontUpdate,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic [31:0] ifInstruction,
  output logic [31:0] ifProgramCounter
);

  fetch_state_e state_q, state_d;
  logic [31:0]  buf_data_q, buf_data_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  pc;
  logic         req_fire;
  logic         capture;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk      (clk),
    .reset    (reset),
    .load_i   (redirectValid),
    .target_i (redirectTarget),
    .incr_i   (capture),
    .pc_o     (pc)
  );

  // A consumed FULL entry issues its successor in the same cycle.
  assign imemReqValid = !reset && !redirectValid &&
                        (state_q == ISSUE || (state_q == FULL && !dontUpdate));
  assign imemReqAddr  = pc;
  assign req_fire     = imemReqValid && imemReqReady;
  assign capture      = (state_q == WAIT) && imemRespValid && !redirectValid;

  assign ifInstruction    = (state_q == FULL) ? buf_data_q : NOP_INSTR;
  assign ifProgramCounter = (state_q == FULL) ? buf_pc_q : 32'h0;

  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (capture) begin
      buf_data_d = imemRespData;
      buf_pc_d   = pc;
    end
    unique case (state_q)
      ISSUE: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (imemRespValid) begin
          state_d = redirectValid ? ISSUE : FULL;
        end else if (redirectValid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imemRespValid) state_d = ISSUE;
      end
      FULL: begin
        if (redirectValid) begin
          state_d = ISSUE;
        end else if (!dontUpdate) begin
          state_d = req_fire ? WAIT : ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ISSUE;
      buf_data_q <= NOP_INSTR;
      buf_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: random/directed stimulus, behavioural imem model and
// a scoreboard of expected offered instructions checked by an independent monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        dontUpdate;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic [31:0] ifInstruction;
  logic [31:0] ifProgramCounter;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .dontUpdate       (dontUpdate),
    .redirectValid    (redirectValid),
    .redirectTarget   (redirectTarget),
    .imemReqValid     (imemReqValid),
    .imemReqAddr      (imemReqAddr),
    .imemReqReady     (imemReqReady),
    .imemRespValid    (imemRespValid),
    .imemRespData     (imemRespData),
    .ifInstruction    (ifInstruction),
    .ifProgramCounter (ifProgramCounter)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } instr_t;

  instr_t      exp_q[$];
  logic [31:0] next_req;
  bit          mem_out;
  bit          mem_sq;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat_cfg = 1;
  bit          prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Memory model, reference model and scoreboard monitor; samples on the falling edge.
  initial begin
    imemRespValid = 1'b0;
    imemRespData  = 32'h0;
    mem_out       = 1'b0;
    mem_sq        = 1'b0;
    prev_stall    = 1'b0;
    next_req      = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        imemRespValid = 1'b0;
        mem_out       = 1'b0;
        mem_sq        = 1'b0;
        prev_stall    = 1'b0;
        next_req      = 32'h0;
        exp_q.delete();
        check(!imemReqValid, "req_in_reset", {31'h0, imemReqValid}, 32'h0);
      end else begin
        imemRespValid = 1'b0;
        if (mem_out) begin
          if (mem_wait == 0) begin
            imemRespValid = 1'b1;
            imemRespData  = mem_word(mem_addr);
          end else begin
            mem_wait--;
          end
        end

        if (ifInstruction != NOP) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_instr", ifProgramCounter, 32'h0);
          end else begin
            check(ifProgramCounter == exp_q[0].pc, "offered_pc", ifProgramCounter, exp_q[0].pc);
            check(ifInstruction == exp_q[0].data, "offered_data", ifInstruction, exp_q[0].data);
            check(imemReqValid == (!dontUpdate && !redirectValid), "req_while_full",
                  {31'h0, imemReqValid}, {31'h0, !dontUpdate && !redirectValid});
            // Consumed by IF/ID, or squashed by a redirect.
            if (redirectValid || !dontUpdate) void'(exp_q.pop_front());
          end
        end else begin
          check(ifProgramCounter == 32'h0, "bubble_pc", ifProgramCounter, 32'h0);
          check(exp_q.size() == 0, "lost_instr", exp_q.size(), 32'h0);
        end

        if (prev_stall && !redirectValid) begin
          check(imemReqValid, "req_dropped", {31'h0, imemReqValid}, 32'h1);
          check(imemReqAddr == prev_addr, "req_addr_stable", imemReqAddr, prev_addr);
        end
        prev_stall = imemReqValid && !imemReqReady;
        prev_addr  = imemReqAddr;

        if (redirectValid && mem_out) mem_sq = 1'b1;
        if (imemRespValid) begin
          mem_out = 1'b0;
          if (!mem_sq) begin
            exp_q.push_back({mem_addr, mem_word(mem_addr)});
            next_req = mem_addr + 32'd4;
          end
        end
        if (redirectValid) next_req = redirectTarget & 32'hFFFF_FFFC;

        if (imemReqValid && imemReqReady) begin
          check(!mem_out, "second_outstanding", {31'h0, mem_out}, 32'h0);
          check(imemReqAddr == next_req, "req_addr", imemReqAddr, next_req);
          mem_out  = 1'b1;
          mem_sq   = 1'b0;
          mem_addr = imemReqAddr;
          mem_wait = lat_cfg - 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_offered(input bit any_pc, input logic [31:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (ifInstruction != NOP && (any_pc || ifProgramCounter == pc)) seen = 1'b1;
      else cyc();
    end
    if (!seen) check(1'b0, "timeout_offered", ifProgramCounter, pc);
  endtask

  task automatic wait_fire();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && mem_out; i++) cyc();
    for (int i = 0; i < 60 && !seen; i++) begin
      if (mem_out) seen = 1'b1;
      else cyc();
    end
    if (!seen) check(1'b0, "timeout_fire", 32'h0, 32'h1);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirectValid  = 1'b1;
    redirectTarget = t;
    cyc();
    redirectValid  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    dontUpdate     = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = 32'h0;
    imemReqReady   = 1'b1;
    run(2);
    reset = 1'b0;

    // Free run to the instruction at 8, then stall it for three cycles.
    wait_offered(1'b0, 32'h8);
    dontUpdate = 1'b1;
    run(3);
    dontUpdate = 1'b0;
    run(2);

    // Redirect while waiting; the late response must be dropped.
    lat_cfg = 3;
    wait_fire();
    redirect(32'h100);
    run(8);

    // Redirect coincident with the response.
    lat_cfg = 1;
    wait_fire();
    redirect(32'h40);
    run(6);

    // Redirect while an instruction is offered.
    wait_offered(1'b1, 32'h0);
    redirect(32'h80);
    run(6);

    // Wrap-around fetch with a back-pressured request.
    wait_offered(1'b1, 32'h0);
    imemReqReady = 1'b0;
    redirect(32'hFFFF_FFFC);
    run(4);
    imemReqReady = 1'b1;
    run(10);

    // Reset while a request is in flight.
    lat_cfg = 3;
    wait_fire();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(8);

    for (int i = 0; i < 800; i++) begin
      reset          = ($urandom_range(99) == 0);
      redirectValid  = ($urandom_range(9) == 0);
      redirectTarget = $urandom;
      dontUpdate     = ($urandom_range(2) == 0);
      imemReqReady   = ($urandom_range(3) != 0);
      lat_cfg        = $urandom_range(3, 1);
      cyc();
    end

    reset         = 1'b0;
    redirectValid = 1'b0;
    dontUpdate    = 1'b0;
    imemReqReady  = 1'b1;
    run(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the IF-side inputs (ifInstruction, ifProgramCounter) of the IF/ID pipeline register.
- Owns the program counter and runs a single-outstanding valid/ready request plus response handshake to instruction memory.
- Holds a fetched instruction while the hazard unit stalls, presents a NOP bubble when nothing is ready, and handles branch/jump redirects, including discarding an in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- dontUpdate  input  1  stall from hazard unit; the same signal gates the IF/ID register.
- redirectValid  input  1  branch/jump taken; fetch must restart at redirectTarget.
- redirectTarget  input  32  new PC; bits [1:0] are ignored (forced 0).
- imemReqValid  output  1  fetch request valid.
- imemReqAddr  output  32  fetch address.
- imemReqReady  input  1  memory accepts the request this cycle.
- imemRespValid  input  1  response data valid; exactly one response per accepted request.
- imemRespData  input  32  instruction word.
- ifInstruction  output  32  instruction offered to IF/ID.
- ifProgramCounter  output  32  PC of ifInstruction.

Behaviour:
- Registers: pc[31:0] (next fetch address), state, bufData[31:0], bufPc[31:0].
- States: ISSUE, WAIT, DISCARD, FULL.
- Reset (synchronous, dominates all other inputs): pc=RESET_PC, state=ISSUE, bufData=NOP_INSTR, bufPc=0.
- During the reset cycle, imemReqValid=0.
- Outputs (combinational from registers plus redirectValid/dontUpdate):
  - ifInstruction = (state==FULL) ? bufData : NOP_INSTR.
  - ifProgramCounter = (state==FULL) ? bufPc : 0.
  - imemReqAddr = pc.
  - imemReqValid = !reset && !redirectValid && (state==ISSUE || (state==FULL && !dontUpdate)).
- Handshake fires when imemReqValid && imemReqReady.
- ISSUE:
  - redirectValid: pc<=target, stay ISSUE. No request is issued that cycle.
  - Handshake fires: go to WAIT.
  - Otherwise: hold. imemReqValid and imemReqAddr stay stable until accepted.
- WAIT:
  - respValid && !redirectValid: bufData<=respData, bufPc<=pc, pc<=pc+PC_STEP (mod 2^32 wrap), go to FULL.
  - respValid && redirectValid: drop the data, pc<=target, go to ISSUE.
  - !respValid && redirectValid: pc<=target, go to DISCARD.
- DISCARD:
  - respValid: drop the data, go to ISSUE.
  - redirectValid: pc<=target. If respValid is also high, go to ISSUE; otherwise stay in DISCARD.
- FULL (instruction offered):
  - redirectValid (priority over consume): buffer invalidated, pc<=target, go to ISSUE.
  - dontUpdate=0: instruction consumed by IF/ID this edge. Next request is issued the same cycle: go to WAIT if the handshake fires, else ISSUE.
  - dontUpdate=1: hold bufData/bufPc unchanged and issue no request.
- Latency and throughput:
  - With a 1-cycle memory, an instruction is offered 2 cycles after request acceptance.
  - Steady-state throughput is 1 instruction per 2 cycles.
- dontUpdate outside FULL does not stop fetching. The bubble is simply not consumed.
- Response arriving in ISSUE or FULL is a protocol violation; the bench asserts it never happens.
- Instruction memory shares reset, so no stale response survives reset.
- Target: a one-hot-free 2-bit encoded FSM, no latches.

Decomposition:
- Shared package (cpu_pkg):
  - NOP_INSTR, PC_STEP and RESET_PC defaults.
  - fetch-state enum {ISSUE, WAIT, DISCARD, FULL}.
- One natural sub-module, pc_register: holds pc and selects among reset/redirect/increment/hold.

Test Plan:
- Reset then free run, 1-cycle memory, dontUpdate=0 -> requests at 0,4,8. Instructions 0xAAAA0000+addr are offered with PC 0,4,8. NOP/PC=0 is offered between them.
- FULL with instr@8, dontUpdate=1 for 3 cycles -> ifInstruction/PC held at 8 and imemReqValid=0. On release, consumed and a request to 12 issues the same cycle.
- Redirect to 0x100 while in WAIT, response arriving 2 cycles later -> response dropped and no FULL. Next request address is 0x100.
- redirectValid and respValid in the same WAIT cycle, target 0x40 -> data dropped and next request address is 0x40.
- FULL with redirectValid=1 and dontUpdate=0, target 0x80 -> buffered instruction not re-offered, bubble output, request address 0x80.
- pc=0xFFFF_FFFC, imemReqReady low 4 cycles then high -> request held stable, then pc wraps to 0x0000_0000. Reset asserted mid-WAIT -> pc=RESET_PC and state ISSUE.
